// File: rtl/neo_clkgen_sync.sv
`default_nettype none
// ============================================================================
// Module      : neo_clkgen_sync
// Description : Single-clock Neo-Geo clock generator. Runs on the 48 MHz
//               master clock and derives the 12M/6MB/3M/1HB and 68KCLK
//               levels from 24 MHz edge enables, together with one-cycle
//               enable pulses that announce each level edge one cycle early.
// Revision    : 1.0 - initial release
// ============================================================================
module neo_clkgen_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic CLK_EN_24M_P,
  input  logic CLK_EN_24M_N,
  output logic CLK_12M,
  output logic CLK_EN_12M,
  output logic CLK_EN_12M_N,
  output logic CLK_68KCLK,
  output logic CLK_68KCLKB,
  output logic CLK_EN_68K_P,
  output logic CLK_EN_68K_N,
  output logic CLK_6MB,
  output logic CLK_EN_6MB,
  output logic CLK_3M,
  output logic CLK_1HB,
  output logic CLK_EN_1HB
);

  // Divider chain advanced on 24 MHz falling edges; bit 0 is 12M, bit 1 is
  // 6M, bit 2 is 3M.
  logic [2:0] div;
  // 68000 clock phase, advanced on 24 MHz rising edges so it sits half a
  // 24 MHz period away from CLK_12M.
  logic       k68;

  // Divider counter: wraps 7 -> 0 naturally through 3-bit arithmetic.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div <= 3'd0;
    end else if (CLK_EN_24M_N) begin
      div <= div + 3'd1;
    end
  end

  // 68000 clock toggle on each 24 MHz rising edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      k68 <= 1'b0;
    end else if (CLK_EN_24M_P) begin
      k68 <= ~k68;
    end
  end

  // Level outputs come straight from the state flops, so RESET has no
  // combinational route to them.
  assign CLK_12M     = div[0];
  assign CLK_6MB     = ~div[1];
  assign CLK_3M      = div[2];
  assign CLK_1HB     = ~div[2];
  assign CLK_68KCLK  = k68;
  assign CLK_68KCLKB = ~k68;

  // Edge enables: asserted in the cycle whose clock edge moves the level,
  // and held off entirely while the block is in reset.
  always_comb begin
    CLK_EN_12M   = 1'b0;
    CLK_EN_12M_N = 1'b0;
    CLK_EN_6MB   = 1'b0;
    CLK_EN_1HB   = 1'b0;
    CLK_EN_68K_P = 1'b0;
    CLK_EN_68K_N = 1'b0;
    if (!RESET) begin
      CLK_EN_12M   = CLK_EN_24M_N & ~div[0];
      CLK_EN_12M_N = CLK_EN_24M_N & div[0];
      CLK_EN_6MB   = CLK_EN_24M_N & (div[1:0] == 2'd3);
      CLK_EN_1HB   = CLK_EN_24M_N & (div == 3'd7);
      CLK_EN_68K_P = CLK_EN_24M_P & ~k68;
      CLK_EN_68K_N = CLK_EN_24M_P & k68;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neo_clkgen_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_neo_clkgen_sync
// Description : Directed, self-checking bench for neo_clkgen_sync. A small
//               reference model predicts enables in the driven cycle and
//               queues the level outputs expected after the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neo_clkgen_sync;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic CLK_EN_24M_P = 1'b0;
  logic CLK_EN_24M_N = 1'b0;
  logic CLK_12M, CLK_EN_12M, CLK_EN_12M_N, CLK_68KCLK, CLK_68KCLKB;
  logic CLK_EN_68K_P, CLK_EN_68K_N, CLK_6MB, CLK_EN_6MB, CLK_3M, CLK_1HB, CLK_EN_1HB;

  neo_clkgen_sync dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CLK_EN_24M_P (CLK_EN_24M_P),
    .CLK_EN_24M_N (CLK_EN_24M_N),
    .CLK_12M      (CLK_12M),
    .CLK_EN_12M   (CLK_EN_12M),
    .CLK_EN_12M_N (CLK_EN_12M_N),
    .CLK_68KCLK   (CLK_68KCLK),
    .CLK_68KCLKB  (CLK_68KCLKB),
    .CLK_EN_68K_P (CLK_EN_68K_P),
    .CLK_EN_68K_N (CLK_EN_68K_N),
    .CLK_6MB      (CLK_6MB),
    .CLK_EN_6MB   (CLK_EN_6MB),
    .CLK_3M       (CLK_3M),
    .CLK_1HB      (CLK_1HB),
    .CLK_EN_1HB   (CLK_EN_1HB)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [2:0] m_div = 3'd0;
  logic       m_k68 = 1'b0;

  // Expected level vectors {12M, 6MB, 3M, 1HB, 68K, 68KB}
  logic [5:0] exp_q[$];

  // Enable vector of the most recent step {12M, 12M_N, 6MB, 1HB, 68K_P, 68K_N}
  logic [5:0] last_en;
  int c12, c12n, c6, c1h;

  function automatic logic [5:0] levels_of(input logic [2:0] d, input logic k);
    return {d[0], ~d[1], d[2], ~d[2], k, ~k};
  endfunction

  // One CLK cycle: drive inputs, check enables, predict and check levels.
  task automatic step(input logic rst, input logic p, input logic n);
    logic [5:0] e_en, a_en, e_lv, a_lv;
    logic old_6mb, old_1hb;
    RESET = rst; CLK_EN_24M_P = p; CLK_EN_24M_N = n;
    #2;
    e_en = 6'b0;
    if (!rst) begin
      e_en[5] = n & (m_div[0] == 1'b0);
      e_en[4] = n & (m_div[0] == 1'b1);
      e_en[3] = n & (m_div % 4 == 3);
      e_en[2] = n & (m_div == 3'd7);
      e_en[1] = p & (m_k68 == 1'b0);
      e_en[0] = p & (m_k68 == 1'b1);
    end
    a_en = {CLK_EN_12M, CLK_EN_12M_N, CLK_EN_6MB, CLK_EN_1HB, CLK_EN_68K_P, CLK_EN_68K_N};
    checks++;
    assert (a_en === e_en) else begin
      errors++;
      $error("FAIL enables t=%0t observed=%b expected=%b", $time, a_en, e_en);
    end
    last_en = a_en;
    c12  += int'(a_en[5]);
    c12n += int'(a_en[4]);
    c6   += int'(a_en[3]);
    c1h  += int'(a_en[2]);
    if (rst) begin
      m_div = 3'd0; m_k68 = 1'b0;
    end else begin
      if (n) m_div = m_div + 3'd1;
      if (p) m_k68 = ~m_k68;
    end
    exp_q.push_back(levels_of(m_div, m_k68));
    old_6mb = CLK_6MB;
    old_1hb = CLK_1HB;
    @(posedge CLK);
    #1;
    a_lv = {CLK_12M, CLK_6MB, CLK_3M, CLK_1HB, CLK_68KCLK, CLK_68KCLKB};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL levels scoreboard empty observed=%b expected=entry", a_lv);
    end else begin
      e_lv = exp_q.pop_front();
      assert (a_lv === e_lv) else begin
        errors++;
        $error("FAIL levels t=%0t observed=%b expected=%b", $time, a_lv, e_lv);
      end
    end
    if (a_en[3]) begin
      checks++;
      assert ({old_6mb, CLK_6MB} === 2'b01) else begin
        errors++;
        $error("FAIL en6mb_edge observed=%b expected=01", {old_6mb, CLK_6MB});
      end
    end
    if (a_en[2]) begin
      checks++;
      assert ({old_1hb, CLK_1HB} === 2'b01) else begin
        errors++;
        $error("FAIL en1hb_edge observed=%b expected=01", {old_1hb, CLK_1HB});
      end
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int npulse;
    bit found;
    @(posedge CLK);
    #1;

    // Reset with enables toggling
    for (int i = 0; i < 4; i++) step(1'b1, i[0], ~i[0]);

    // Nominal run: 64 CLK alternating P/N
    c12 = 0; c12n = 0; c6 = 0; c1h = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
    end
    check_int("count_en12m", c12, 16);
    check_int("count_en12m_n", c12n, 16);
    check_int("count_en6mb", c6, 8);
    check_int("count_en1hb", c1h, 4);

    // Advance to DIV=5, then hold both enables low
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (i[0]) step(1'b0, 1'b0, 1'b1); else step(1'b0, 1'b1, 1'b0);
      if (m_div == 3'd5) found = 1;
    end
    check_int("reach_div5", int'(found), 1);
    c12 = 0; c12n = 0; c6 = 0; c1h = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    check_int("hold_no_pulses", c12 + c12n + c6 + c1h, 0);

    // Resume: 1HB enable arrives on the third falling-edge enable
    npulse = 0;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      npulse++;
      if (last_en[2]) found = 1;
    end
    check_int("resume_1hb_pulses", npulse, 3);

    // Both enables together act independently
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);

    // Reach DIV=6, K68=1, then a one-cycle reset
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (i[0]) step(1'b0, 1'b0, 1'b1); else step(1'b0, 1'b1, 1'b0);
      if (m_div == 3'd6 && m_k68) found = 1;
    end
    check_int("reach_div6_k68", int'(found), 1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check_int("post_reset_en12m", int'(last_en[5]), 1);
    for (int i = 0; i < 8; i++) step(1'b0, i[0], ~i[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
